adder0: RTL and testbench

ADDER0 -- requirements
Module: adder0

---
 rtl/adder0_if.sv | 35 +++
 rtl/adder0.sv | 87 ++++++++
 tb/tb_adder0.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder0_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder0_if
//  Description : Beat-level bus for the adder0 full/serial adder. The master
//                drives the operand beat, the slave returns the registered
//                per-beat result and the assembled serial word.
//  Revision    : 1.0  initial release
// ============================================================================
interface adder0_if #(
    parameter int WIDTH = 8
);
    logic             x;
    logic             y;
    logic             Cin;
    logic             in_valid;
    logic             serial_en;
    logic             serial_start;
    logic             Sum;
    logic             Cout;
    logic             out_valid;
    logic [WIDTH-1:0] word_sum;
    logic             word_cout;
    logic             word_done;

    modport master (
        output x, y, Cin, in_valid, serial_en, serial_start,
        input  Sum, Cout, out_valid, word_sum, word_cout, word_done
    );

    modport slave (
        input  x, y, Cin, in_valid, serial_en, serial_start,
        output Sum, Cout, out_valid, word_sum, word_cout, word_done
    );
endinterface
`default_nettype wire

// File: rtl/adder0.sv
`default_nettype none
// ============================================================================
//  Module      : adder0
//  Description : Registered full adder. Each accepted beat is either an
//                independent full-add or one bit (LSB first) of a WIDTH-bit
//                bit-serial addition whose carry is kept between beats.
//  Revision    : 1.0  initial release
// ============================================================================
module adder0 #(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    adder0_if.slave   bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic               r_sum;
    logic               r_cout;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_word_sum;
    logic               r_word_cout;
    logic               r_word_done;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_cin_eff;
    logic               w_sum;
    logic               w_cout;
    logic [c_CNT_W-1:0] w_idx;
    logic               w_last;

    // Carry selection, one-bit add, and position of this beat inside the word.
    // serial_start forces bit 0, which also aborts any partial word in flight.
    always_comb begin
        w_cin_eff       = (!bus.serial_en || bus.serial_start) ? bus.Cin : r_carry;
        {w_cout, w_sum} = {1'b0, bus.x} + {1'b0, bus.y} + {1'b0, w_cin_eff};
        w_idx           = bus.serial_start ? '0 : r_cnt;
        w_last          = (w_idx == c_LAST);
    end

    // Result registers, serial carry, bit counter and word assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_word_sum  <= '0;
            r_word_cout <= 1'b0;
            r_word_done <= 1'b0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            r_word_done <= 1'b0;
            if (bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                if (!bus.serial_en) begin
                    r_carry <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_word_sum <= {w_sum, r_word_sum[WIDTH-1:1]};
                    if (w_last) begin
                        r_word_done <= 1'b1;
                        r_word_cout <= w_cout;
                        r_carry     <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_carry <= w_cout;
                        r_cnt   <= w_idx + c_ONE;
                    end
                end
            end
        end
    end

    assign bus.Sum       = r_sum;
    assign bus.Cout      = r_cout;
    assign bus.out_valid = r_out_valid;
    assign bus.word_sum  = r_word_sum;
    assign bus.word_cout = r_word_cout;
    assign bus.word_done = r_word_done;
endmodule
`default_nettype wire

// File: tb/tb_adder0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder0
//  Description : Self-checking bench for adder0: directed truth table and
//                serial words plus randomized beats against a word-level
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder0;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder0_if #(.WIDTH(W)) bus ();

    adder0 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit          m_sum, m_cout, m_wcout, m_carry, m_cin0;
    int          m_idx;
    logic [63:0] m_a, m_b;

    // observations of the last completed word
    logic [W-1:0] last_wsum;
    logic         last_wcout;
    int           done_count = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sum   = 1'b0;
        m_cout  = 1'b0;
        m_wcout = 1'b0;
        m_carry = 1'b0;
        m_idx   = 0;
        m_a     = '0;
        m_b     = '0;
        m_cin0  = 1'b0;
    endtask

    // One clock: present a beat, predict, then check one cycle later.
    task automatic beat(input bit v, input bit se, input bit ss,
                        input bit xx, input bit yy, input bit cc);
        bit          exp_done;
        bit          cin_eff;
        int          t;
        logic [63:0] full;
        logic [63:0] exp_wsum;
        exp_done = 1'b0;
        exp_wsum = '0;
        @(negedge clk);
        bus.in_valid     = v;
        bus.serial_en    = se;
        bus.serial_start = ss;
        bus.x            = xx;
        bus.y            = yy;
        bus.Cin          = cc;
        if (v) begin
            if (!se) begin
                t       = int'(xx) + int'(yy) + int'(cc);
                m_carry = 1'b0;
                m_idx   = 0;
            end else begin
                if (ss) m_idx = 0;
                if (m_idx == 0) begin
                    m_a    = '0;
                    m_b    = '0;
                    m_cin0 = ss ? cc : 1'b0;
                end
                cin_eff = ss ? cc : m_carry;
                t       = int'(xx) + int'(yy) + int'(cin_eff);
                m_a[m_idx] = xx;
                m_b[m_idx] = yy;
                if (m_idx == W - 1) begin
                    full     = m_a + m_b + 64'(m_cin0);
                    exp_done = 1'b1;
                    exp_wsum = full & ((64'd1 << W) - 64'd1);
                    m_wcout  = full[W];
                    m_idx    = 0;
                    m_carry  = 1'b0;
                end else begin
                    m_idx++;
                    m_carry = t[1];
                end
            end
            m_sum  = t[0];
            m_cout = t[1];
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(v));
        chk("Sum", 64'(bus.Sum), 64'(m_sum));
        chk("Cout", 64'(bus.Cout), 64'(m_cout));
        chk("word_done", 64'(bus.word_done), 64'(exp_done));
        chk("word_cout", 64'(bus.word_cout), 64'(m_wcout));
        if (exp_done) chk("word_sum", 64'(bus.word_sum), exp_wsum);
        if (bus.word_done) begin
            done_count++;
            last_wsum  = bus.word_sum;
            last_wcout = bus.word_cout;
        end
    endtask

    // Reset for one cycle with a live beat presented; it must be discarded.
    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.in_valid     = 1'b1;
        bus.serial_en    = 1'b1;
        bus.serial_start = 1'b1;
        bus.x            = 1'b1;
        bus.y            = 1'b1;
        bus.Cin          = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst Sum", 64'(bus.Sum), 64'd0);
        chk("rst Cout", 64'(bus.Cout), 64'd0);
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst word_sum", 64'(bus.word_sum), 64'd0);
        chk("rst word_cout", 64'(bus.word_cout), 64'd0);
        chk("rst word_done", 64'(bus.word_done), 64'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    // Full serial word, LSB first; Cin held on every beat (only bit 0 uses it).
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit cin, input bit gaps);
        for (int i = 0; i < W; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0)
                    beat(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            beat(1'b1, 1'b1, (i == 0), a[i], b[i], cin);
        end
    endtask

    initial begin
        int          d0;
        logic [2:0]  tt_in;
        logic [1:0]  tt_exp [8];
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.serial_en    = 1'b0;
        bus.serial_start = 1'b0;
        bus.x            = 1'b0;
        bus.y            = 1'b0;
        bus.Cin          = 1'b0;
        model_reset();
        do_reset();

        // independent full-add truth table; serial_start must be ignored
        for (int i = 0; i < 8; i++) begin
            tt_in = 3'(i);
            beat(1'b1, 1'b0, 1'($urandom), tt_in[2], tt_in[1], tt_in[0]);
            chk("truth table", 64'({bus.Cout, bus.Sum}), 64'(tt_exp[i]));
        end

        // 0x5A + 0x3C
        d0 = done_count;
        send_word(8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("5A+3C done count", 64'(done_count - d0), 64'd1);
        chk("5A+3C word_sum", 64'(last_wsum), 64'h96);
        chk("5A+3C word_cout", 64'(last_wcout), 64'd0);

        // overflow, then no stale carry
        send_word(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("FF+01 word_sum", 64'(last_wsum), 64'h00);
        chk("FF+01 word_cout", 64'(last_wcout), 64'd1);
        send_word(8'h00, 8'h00, 1'b1, 1'b0);
        chk("00+00+1 word_sum", 64'(last_wsum), 64'h01);
        chk("00+00+1 word_cout", 64'(last_wcout), 64'd0);

        // gaps inside a word give the same result
        send_word(8'h5A, 8'h3C, 1'b0, 1'b1);
        chk("gapped word_sum", 64'(last_wsum), 64'h96);

        // abort after 3 bits, then a full word
        d0 = done_count;
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, (i == 0), 1'b1, 1'b1, 1'b1);
        send_word(8'hC3, 8'h4E, 1'b1, 1'b0);
        chk("abort done count", 64'(done_count - d0), 64'd1);
        chk("abort word_sum", 64'(last_wsum), 64'h12);
        chk("abort word_cout", 64'(last_wcout), 64'd1);

        // reset mid-word, then a full word
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, (i == 0), 1'b1, 1'b0, 1'b1);
        do_reset();
        send_word(8'h81, 8'h7F, 1'b0, 1'b0);
        chk("post-reset word_sum", 64'(last_wsum), 64'h00);
        chk("post-reset word_cout", 64'(last_wcout), 64'd1);

        // serial beats without a start after completion: fresh word, carry 0
        for (int i = 0; i < W; i++) beat(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1);

        // random gapped words
        for (int k = 0; k < 20; k++)
            send_word(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        // fully random beat stream
        for (int k = 0; k < 400; k++)
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
